// File: rtl/fb_port_arbiter.sv
// Round-robin arbiter sharing the single-port 1-bit frame buffer RAM between N_REQ requesters.
// Owners hold the port for bursts; a hold counter forces a handover when others are waiting.
module fb_port_arbiter #(
  parameter int N_REQ      = 3,
  parameter int PIXEL_NUM  = 76800,
  parameter int ADDR_WIDTH = $clog2(PIXEL_NUM),
  parameter int MAX_HOLD   = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            req_we,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ-1:0]            req_data,
  output logic [N_REQ-1:0]            gnt,
  output logic [N_REQ-1:0]            rvalid,
  output logic                        rdata,
  output logic [ADDR_WIDTH-1:0]       ram_addr,
  output logic                        ram_data,
  output logic                        ram_write_en,
  input  logic                        ram_q,
  output logic                        addr_err
);

  localparam int OW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HW  = $clog2(MAX_HOLD + 1);
  localparam int AW1 = ADDR_WIDTH + 1;
  localparam logic [AW1-1:0] PixLimit = AW1'(PIXEL_NUM);

  typedef enum logic [0:0] {StIdle, StOwned} state_e;

  state_e           r_state, w_state_nxt;
  logic [OW-1:0]    r_owner, w_owner_nxt;
  logic [OW-1:0]    r_last, w_last_nxt;
  logic [HW-1:0]    r_hold, w_hold_nxt;
  logic [N_REQ-1:0] r_rvalid, w_rvalid_nxt;
  logic             r_rd_bad, w_rd_bad_nxt;
  logic             r_addr_err, w_addr_err_nxt;

  logic [N_REQ-1:0]      w_own_oh;
  logic [ADDR_WIDTH-1:0] w_own_addr;
  logic                  w_own_req, w_own_we, w_own_data, w_own_legal, w_beat;

  logic [OW-1:0]    w_rr_base, w_rr_idx, w_rr_pick;
  logic [N_REQ-1:0] w_rr_mask;
  logic             w_rr_found;

  assign w_own_oh   = N_REQ'(1) << r_owner;
  assign w_own_req  = |(req & w_own_oh);
  assign w_own_we   = |(req_we & w_own_oh);
  assign w_own_data = |(req_data & w_own_oh);

  always_comb begin
    w_own_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_owner == OW'(i)) w_own_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  assign w_own_legal = {1'b0, w_own_addr} < PixLimit;
  assign w_beat      = (r_state == StOwned) && w_own_req;

  // In OWNED the search skips the current owner, which doubles as the new last-owner pointer.
  assign w_rr_base = (r_state == StIdle) ? r_last : r_owner;
  assign w_rr_mask = (r_state == StIdle) ? req : (req & ~w_own_oh);

  always_comb begin
    w_rr_found = 1'b0;
    w_rr_pick  = '0;
    w_rr_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_rr_idx = OW'((int'(w_rr_base) + k) % N_REQ);
      if (!w_rr_found && w_rr_mask[w_rr_idx]) begin
        w_rr_found = 1'b1;
        w_rr_pick  = w_rr_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_last_nxt     = r_last;
    w_hold_nxt     = r_hold;
    w_rvalid_nxt   = '0;
    w_rd_bad_nxt   = 1'b0;
    w_addr_err_nxt = r_addr_err;
    unique case (r_state)
      StIdle: begin
        if (w_rr_found) begin
          w_owner_nxt = w_rr_pick;
          w_hold_nxt  = '0;
          w_state_nxt = StOwned;
        end
      end
      StOwned: begin
        if (!w_own_req) begin
          w_last_nxt = r_owner;
          w_hold_nxt = '0;
          if (w_rr_found) w_owner_nxt = w_rr_pick;
          else            w_state_nxt = StIdle;
        end else begin
          if (!w_own_we) begin
            w_rvalid_nxt = w_own_oh;
            w_rd_bad_nxt = !w_own_legal;
          end
          if (!w_own_legal) w_addr_err_nxt = 1'b1;
          // The beat that completes MAX_HOLD hands over if anyone else is waiting.
          if ((r_hold >= HW'(MAX_HOLD - 1)) && w_rr_found) begin
            w_last_nxt  = r_owner;
            w_owner_nxt = w_rr_pick;
            w_hold_nxt  = '0;
          end else if (r_hold < HW'(MAX_HOLD)) begin
            w_hold_nxt = r_hold + HW'(1);
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_owner    <= '0;
      r_last     <= OW'(N_REQ - 1);
      r_hold     <= '0;
      r_rvalid   <= '0;
      r_rd_bad   <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_last     <= w_last_nxt;
      r_hold     <= w_hold_nxt;
      r_rvalid   <= w_rvalid_nxt;
      r_rd_bad   <= w_rd_bad_nxt;
      r_addr_err <= w_addr_err_nxt;
    end
  end

  assign gnt          = w_beat ? w_own_oh : '0;
  assign ram_addr     = w_beat ? w_own_addr : '0;
  assign ram_data     = w_beat & w_own_data;
  assign ram_write_en = w_beat & w_own_we & w_own_legal;
  assign rvalid       = r_rvalid;
  assign rdata        = ram_q & ~r_rd_bad;
  assign addr_err     = r_addr_err;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Scoreboard bench for fb_port_arbiter: directed bursts push expected RAM writes and read returns,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_fb_port_arbiter;

  localparam int N  = 3;
  localparam int PN = 76800;
  localparam int AW = 17;
  localparam int MH = 64;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req, req_we, req_data, gnt, rvalid;
  logic [N*AW-1:0] req_addr;
  logic            rdata, ram_data, ram_write_en, ram_q, addr_err;
  logic [AW-1:0]   ram_addr;

  logic          drv_req[N];
  logic          drv_we[N];
  logic          drv_data[N];
  logic [AW-1:0] drv_addr[N];
  logic          done_flag[N];

  fb_port_arbiter #(
    .N_REQ(N), .PIXEL_NUM(PN), .ADDR_WIDTH(AW), .MAX_HOLD(MH)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_data(req_data), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .ram_addr(ram_addr),
    .ram_data(ram_data), .ram_write_en(ram_write_en), .ram_q(ram_q), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    req      = '0;
    req_we   = '0;
    req_data = '0;
    req_addr = '0;
    for (int i = 0; i < N; i++) begin
      req[i]               = drv_req[i];
      req_we[i]            = drv_we[i];
      req_data[i]          = drv_data[i];
      req_addr[i*AW +: AW] = drv_addr[i];
    end
  end

  // RAM model; out-of-range reads float high so the DUT's forced-zero is visible.
  logic mem [PN];
  always @(posedge clk) begin
    if (ram_write_en && (ram_addr < AW'(PN))) mem[ram_addr] <= ram_data;
    ram_q <= (ram_addr < AW'(PN)) ? mem[ram_addr] : 1'b1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int c; int a; logic d;} wexp_t;
  typedef struct {int c; logic [N-1:0] v; logic d;} rexp_t;
  wexp_t wq[$];
  rexp_t rq[$];

  int   n_chk = 0;
  int   n_pass = 0;
  int   beats[N];
  int   b0[N];
  logic done = 1'b0;
  int   t;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_w(input int c, input int a, input logic d);
    wexp_t e;
    e.c = c; e.a = a; e.d = d;
    wq.push_back(e);
  endtask

  task automatic push_r(input int c, input logic [N-1:0] v, input logic d);
    rexp_t e;
    e.c = c; e.v = v; e.d = d;
    rq.push_back(e);
  endtask

  task automatic drive(input int idx, input int n, input logic [31:0] wepat, input int base,
                       input logic [31:0] dpat, input int delay);
    int   k = 0;
    int   budget = 600;
    logic acc;
    done_flag[idx] = 1'b0;
    if (delay > 0) begin
      repeat (delay) @(posedge clk);
      #1;
    end
    while (k < n && budget > 0) begin
      drv_req[idx]  = 1'b1;
      drv_we[idx]   = wepat[5'(k)];
      drv_addr[idx] = AW'(base + k);
      drv_data[idx] = dpat[5'(k)];
      @(negedge clk);
      acc = gnt[idx];
      @(posedge clk);
      #1;
      budget--;
      if (reset) break;
      if (acc) k++;
    end
    drv_req[idx]   = 1'b0;
    done_flag[idx] = (k == n);
  endtask

  task automatic monitor();
    wexp_t w;
    rexp_t r;
    while (!done) begin
      @(negedge clk);
      if (!reset) begin
        if (gnt != '0) chk("gnt_onehot", int'($onehot(gnt)), 1);
        for (int i = 0; i < N; i++) if (gnt[i] && req[i]) beats[i]++;
        if (ram_write_en) begin
          if (wq.size() == 0) chk("unexpected_write_addr", int'(ram_addr), -1);
          else begin
            w = wq.pop_front();
            chk("write_cycle", cyc, w.c);
            chk("write_addr", int'(ram_addr), w.a);
            chk("write_data", int'(ram_data), int'(w.d));
          end
        end
        if (rvalid != '0) begin
          if (rq.size() == 0) chk("unexpected_rvalid", int'(rvalid), 0);
          else begin
            r = rq.pop_front();
            chk("read_cycle", cyc, r.c);
            chk("read_rvalid", int'(rvalid), int'(r.v));
            chk("read_rdata", int'(rdata), int'(r.d));
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic snap();
    for (int i = 0; i < N; i++) b0[i] = beats[i];
  endtask

  task automatic chk_beats(input int e0, input int e1, input int e2);
    chk("beats_req0", beats[0] - b0[0], e0);
    chk("beats_req1", beats[1] - b0[1], e1);
    chk("beats_req2", beats[2] - b0[2], e2);
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
    chk("write_queue_empty", wq.size(), 0);
    chk("read_queue_empty", rq.size(), 0);
  endtask

  task automatic sequence_all();
    logic [31:0] dp3;
    dp3 = 32'hA5C3_0F69;
    @(posedge clk);
    #1;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_rvalid", int'(rvalid), 0);
    chk("rst_addr_err", int'(addr_err), 0);
    chk("rst_we", int'(ram_write_en), 0);
    chk("rst_ram_addr", int'(ram_addr), 0);

    // Single requester, 10 writes of 1 to addresses 0..9.
    do_reset(); snap();
    @(posedge clk); #1; t = cyc;
    for (int k = 0; k < 10; k++) push_w(t + 1 + k, k, 1'b1);
    drive(0, 10, '1, 0, '1, 0);
    drain();
    chk("t1_done", int'(done_flag[0]), 1);
    chk_beats(10, 0, 0);

    // All three request together: served 0, 1, 2 with one release cycle between bursts.
    do_reset(); snap();
    @(posedge clk); #1; t = cyc;
    for (int k = 0; k < 3; k++) begin
      push_w(t + 1 + k, 100 + k, k[0] ? 1'b0 : 1'b1);
      push_w(t + 5 + k, 200 + k, k[0] ? 1'b0 : 1'b1);
      push_w(t + 9 + k, 300 + k, k[0] ? 1'b0 : 1'b1);
    end
    wq.sort() with (item.c);
    fork
      drive(0, 3, '1, 100, 32'h5, 0);
      drive(1, 3, '1, 200, 32'h5, 0);
      drive(2, 3, '1, 300, 32'h5, 0);
    join
    drain();
    chk("t2_done0", int'(done_flag[0]), 1);
    chk("t2_done2", int'(done_flag[2]), 1);
    chk_beats(3, 3, 3);

    // Starvation guard: req0 streams 200, req1 arrives at cycle 5.
    do_reset(); snap();
    @(posedge clk); #1; t = cyc;
    for (int k = 0; k < 64; k++) push_w(t + 1 + k, k, dp3[5'(k)]);
    for (int j = 0; j < 5; j++) push_w(t + 65 + j, 1000 + j, 1'b1);
    for (int k = 64; k < 200; k++) push_w(t + 71 + k - 64, k, dp3[5'(k)]);
    fork
      drive(0, 200, '1, 0, dp3, 0);
      drive(1, 5, '1, 1000, '1, 5);
    join
    drain();
    chk("t3_done0", int'(done_flag[0]), 1);
    chk("t3_done1", int'(done_flag[1]), 1);
    chk_beats(200, 5, 0);

    // Reads by requester 2 of data written by requester 0.
    do_reset(); snap();
    @(posedge clk); #1; t = cyc;
    push_w(t + 1, 3200, 1'b1); push_w(t + 2, 3201, 1'b0); push_w(t + 3, 3202, 1'b1);
    drive(0, 3, '1, 3200, 32'h5, 0);
    @(posedge clk); #1; t = cyc;
    push_r(t + 2, 3'b100, 1'b1); push_r(t + 3, 3'b100, 1'b0); push_r(t + 4, 3'b100, 1'b1);
    drive(2, 3, '0, 3200, '0, 0);
    drain();
    chk_beats(3, 0, 3);

    // Illegal addresses: write suppressed, read returns 0, sticky addr_err.
    do_reset(); snap();
    @(posedge clk); #1;
    drive(0, 1, '1, 76800, '1, 0);
    chk("t5_illegal_write_granted", int'(done_flag[0]), 1);
    chk("addr_err_set", int'(addr_err), 1);
    @(posedge clk); #1; t = cyc;
    push_r(t + 2, 3'b001, 1'b0);
    drive(0, 1, '0, 76801, '0, 0);
    @(posedge clk); #1; t = cyc;
    push_w(t + 1, 5, 1'b1); push_w(t + 2, 6, 1'b1);
    drive(1, 2, '1, 5, '1, 0);
    drain();
    chk("addr_err_sticky", int'(addr_err), 1);
    chk_beats(2, 2, 0);
    do_reset();
    chk("addr_err_cleared", int'(addr_err), 0);

    // Reset during requester 1's 5th beat (beat 3 is a read, beat 4 a write).
    snap();
    @(posedge clk); #1; t = cyc;
    push_w(t + 1, 40, 1'b1); push_w(t + 2, 41, 1'b0); push_w(t + 3, 42, 1'b1);
    fork
      drive(1, 10, 32'hFFFF_FFF7, 40, 32'h5, 0);
      begin
        repeat (5) @(posedge clk);
        #2;
        chk("pre_rst_gnt", int'(gnt), 2);
        chk("pre_rst_rvalid", int'(rvalid), 2);
        chk("pre_rst_we", int'(ram_write_en), 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_gnt", int'(gnt), 0);
        chk("mid_rst_we", int'(ram_write_en), 0);
        chk("mid_rst_rvalid", int'(rvalid), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
      end
    join
    chk("t6_burst_aborted", int'(done_flag[1]), 0);
    chk_beats(0, 4, 0);
    @(posedge clk); #1; t = cyc;
    push_w(t + 1, 50, 1'b1); push_w(t + 3, 60, 1'b1);
    fork
      drive(0, 1, '1, 50, '1, 0);
      drive(1, 1, '1, 60, '1, 0);
    join
    drain();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      drv_req[i]   = 1'b0;
      drv_we[i]    = 1'b0;
      drv_data[i]  = 1'b0;
      drv_addr[i]  = '0;
      done_flag[i] = 1'b0;
      beats[i]     = 0;
      b0[i]        = 0;
    end
    fork
      monitor();
      begin
        sequence_all();
        done = 1'b1;
      end
    join
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
